// File: rtl/wb_timer_if.sv
// Wishbone B4 pipelined bus bundle (32-bit data, byte selects) with master
// and slave views.
interface wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   adr;
  logic [DW/8-1:0] sel;
  logic [DW-1:0]   dat_m;
  logic [DW-1:0]   dat_s;
  logic            ack;
  logic            stall;
  logic            err;

  modport master (
    output cyc, stb, we, adr, sel, dat_m,
    input  dat_s, ack, stall, err
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_m,
    output dat_s, ack, stall, err
  );
endinterface

// File: rtl/wb_timer.sv
// RISC-V machine timer (64-bit mtime/mtimecmp) as a Wishbone pipelined slave,
// with a programmable prescaler and a latched high word for tear-free reads.
module wb_timer #(
  parameter int unsigned PRESCALE_RST = 49,
  parameter int          PW           = 16
) (
  input  logic clk,
  input  logic rst_n,
  wb_if.slave  wb,
  output logic irq_timer
);

  typedef enum logic [2:0] {
    REG_MTIME_LO    = 3'd0,
    REG_MTIME_HI    = 3'd1,
    REG_MTIMECMP_LO = 3'd2,
    REG_MTIMECMP_HI = 3'd3,
    REG_CTRL        = 3'd4,
    REG_PRESCALE    = 3'd5,
    REG_RSVD0       = 3'd6,
    REG_RSVD1       = 3'd7
  } reg_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

  logic          accept;
  logic          wr_en;
  logic          rd_en;
  reg_e          reg_sel;

  logic [31:0]   mtime_lo;
  logic [31:0]   mtime_hi;
  logic [31:0]   cmp_lo;
  logic [31:0]   cmp_hi;
  logic [31:0]   shadow;
  logic          en;
  logic [PW-1:0] prescale;
  logic [PW-1:0] count;
  logic          tick;
  logic          lo_carry;

  logic [31:0]   rd_data;
  logic [31:0]   prescale_wr;
  logic          ack_q;
  logic [31:0]   dat_q;
  logic          unused_adr;

  assign accept  = wb.cyc & wb.stb;
  assign wr_en   = accept & wb.we;
  assign rd_en   = accept & ~wb.we;
  assign reg_sel = reg_e'(wb.adr[4:2]);

  // The interconnect owns the window, so only adr[4:2] is meaningful here.
  assign unused_adr = ^{wb.adr[31:5], wb.adr[1:0]};

  // ---------------------------------------------------------------------------
  // Prescaler: one tick every prescale+1 enabled clocks.
  // ---------------------------------------------------------------------------
  assign tick     = en && (count == prescale);
  assign lo_carry = tick && (mtime_lo == '1);

  // NOTE: state registers use non-blocking assignments so every process sees
  // the pre-edge values, independent of the order the blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (wr_en && reg_sel == REG_PRESCALE) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // mtime: a bus write to a word overrides that word's tick, while the high
  // word still takes the carry produced by the old low word.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_lo <= '0;
    end else if (wr_en && reg_sel == REG_MTIME_LO) begin
      mtime_lo <= byte_merge(mtime_lo, wb.dat_m, wb.sel);
    end else if (tick) begin
      mtime_lo <= mtime_lo + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_hi <= '0;
    end else if (wr_en && reg_sel == REG_MTIME_HI) begin
      mtime_hi <= byte_merge(mtime_hi, wb.dat_m, wb.sel);
    end else if (lo_carry) begin
      mtime_hi <= mtime_hi + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Compare and control registers.
  // ---------------------------------------------------------------------------
  assign prescale_wr = byte_merge(32'(prescale), wb.dat_m, wb.sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_lo   <= '1;
      cmp_hi   <= '1;
      en       <= 1'b1;
      prescale <= PRESCALE_RST[PW-1:0];
    end else if (wr_en) begin
      case (reg_sel)
        REG_MTIMECMP_LO: cmp_lo <= byte_merge(cmp_lo, wb.dat_m, wb.sel);
        REG_MTIMECMP_HI: cmp_hi <= byte_merge(cmp_hi, wb.dat_m, wb.sel);
        REG_CTRL:        if (wb.sel[0]) en <= wb.dat_m[0];
        REG_PRESCALE:    prescale <= prescale_wr[PW-1:0];
        default:         ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: data is sampled at the acceptance edge and presented with ack.
  // ---------------------------------------------------------------------------
  // NOTE: rd_data gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_MTIME_LO:    rd_data = mtime_lo;
      REG_MTIME_HI:    rd_data = shadow;
      REG_MTIMECMP_LO: rd_data = cmp_lo;
      REG_MTIMECMP_HI: rd_data = cmp_hi;
      REG_CTRL:        rd_data = {31'd0, en};
      REG_PRESCALE:    rd_data = 32'(prescale);
      REG_RSVD0,
      REG_RSVD1:       rd_data = '0;
      default:         rd_data = '0;
    endcase
  end

  // Reading the low word freezes the high word so a following HI read pairs
  // with it even if a carry lands in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (rd_en && reg_sel == REG_MTIME_LO) begin
      shadow <= mtime_hi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= accept;
      dat_q <= rd_en ? rd_data : '0;
    end
  end

  assign wb.ack   = ack_q;
  assign wb.dat_s = dat_q;
  assign wb.stall = 1'b0;
  assign wb.err   = 1'b0;

  // ---------------------------------------------------------------------------
  // Interrupt: registered unsigned compare of the current 64-bit values.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_timer <= 1'b0;
    end else begin
      irq_timer <= ({mtime_hi, mtime_lo} >= {cmp_hi, cmp_lo});
    end
  end

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: a cycle-level 64-bit behavioural model
// checked every clock, plus directed transfers with hand-computed results.
module tb_wb_timer;

  logic clk = 1'b0;
  logic rst_n;
  logic irq_timer;

  always #5 clk = ~clk;

  wb_if bus ();

  wb_timer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb        (bus.slave),
    .irq_timer (irq_timer)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] data,
                                         input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  // Behavioural model: whole 64-bit numbers, stepped once per clock.
  logic [63:0] m_time, m_cmp, nt;
  logic [31:0] m_shadow, m_pre, m_cnt, m_dat, rd;
  logic        m_en, m_ack, m_irq, m_tick, acc;
  logic [2:0]  a;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_time = '0; m_cmp = '1; m_shadow = '0; m_en = 1'b1; m_pre = 32'd49;
      m_cnt = '0; m_ack = 1'b0; m_dat = '0; m_irq = 1'b0;
    end else begin
      acc    = bus.cyc & bus.stb;
      a      = bus.adr[4:2];
      m_tick = m_en && (m_cnt == m_pre);
      rd     = '0;
      if (acc && !bus.we) begin
        case (a)
          3'd0: begin rd = m_time[31:0]; m_shadow = m_time[63:32]; end
          3'd1: rd = m_shadow;
          3'd2: rd = m_cmp[31:0];
          3'd3: rd = m_cmp[63:32];
          3'd4: rd = {31'd0, m_en};
          3'd5: rd = m_pre;
          default: rd = '0;
        endcase
      end
      m_irq = (m_time >= m_cmp);
      nt = m_time + {63'd0, m_tick};
      if (m_en) m_cnt = m_tick ? 32'd0 : m_cnt + 32'd1;
      if (acc && bus.we) begin
        case (a)
          3'd0: nt[31:0]  = bmerge(m_time[31:0], bus.dat_m, bus.sel);
          3'd1: nt[63:32] = bmerge(m_time[63:32], bus.dat_m, bus.sel);
          3'd2: m_cmp[31:0]  = bmerge(m_cmp[31:0], bus.dat_m, bus.sel);
          3'd3: m_cmp[63:32] = bmerge(m_cmp[63:32], bus.dat_m, bus.sel);
          3'd4: if (bus.sel[0]) m_en = bus.dat_m[0];
          3'd5: begin m_pre = bmerge(m_pre, bus.dat_m, bus.sel) & 32'h0000_FFFF; m_cnt = '0; end
          default: ;
        endcase
      end
      m_time = nt;
      m_ack  = acc;
      m_dat  = rd;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("model_ack", bus.ack, m_ack);
      check("model_dat", bus.dat_s, m_dat);
      check("model_irq", irq_timer, m_irq);
      check("stall_err", {bus.stall, bus.err}, 64'd0);
    end
  end

  // One transfer; starts and returns on a falling edge (the ack cycle).
  task automatic xfer(input logic w, input logic [4:0] off, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] r);
    bit got;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = w;
    bus.adr = {27'd0, off}; bus.dat_m = d; bus.sel = s;
    @(negedge clk);
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    got = 1'b0;
    r   = '0;
    for (int i = 0; i < 4 && !got; i++) begin
      if (bus.ack === 1'b1) begin
        got = 1'b1;
        r   = bus.dat_s;
        check("ack_latency", i, 0);
      end else begin
        @(negedge clk);
      end
    end
    if (!got) check("ack_timeout", 0, 1);
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    logic [31:0] r;
    xfer(1'b1, off, d, 4'hF, r);
  endtask

  task automatic rd_chk(input string name, input logic [4:0] off, input logic [31:0] exp);
    logic [31:0] r;
    xfer(1'b0, off, 32'd0, 4'hF, r);
    check(name, r, exp);
  endtask

  logic [31:0] b2b_exp [6] = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0};
  logic [4:0]  b2b_adr [6] = '{5'h10, 5'h14, 5'h18, 5'h1C, 5'h10, 5'h14};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.adr = '0; bus.sel = '0; bus.dat_m = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", bus.ack, 0);
    check("rst_dat", bus.dat_s, 0);
    check("rst_irq", irq_timer, 0);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("rst_cmp_hi", 5'h0C, 32'hFFFF_FFFF);
    rd_chk("rst_shadow", 5'h04, 32'd0);
    rd_chk("rst_prescale", 5'h14, 32'd49);
    rd_chk("rst_ctrl", 5'h10, 32'd1);

    // Prescale 3: one tick per 4 clocks.
    wr(5'h10, 32'd1);
    wr(5'h14, 32'd3);
    for (int k = 0; k < 3; k++) begin
      rd_chk("pre3_mtime", 5'h00, k);
      if (k < 2) repeat (3) @(negedge clk);
    end
    rd_chk("pre3_ctrl", 5'h10, 32'd1);
    rd_chk("pre3_prescale", 5'h14, 32'd3);

    // Carry and shadow across the 32-bit wrap.
    wr(5'h14, 32'd0);
    wr(5'h04, 32'd0);
    wr(5'h00, 32'hFFFF_FFFE);
    @(negedge clk);
    rd_chk("wrap_lo_a", 5'h00, 32'hFFFF_FFFF);
    rd_chk("wrap_hi_a", 5'h04, 32'd0);
    rd_chk("wrap_lo_b", 5'h00, 32'd1);
    rd_chk("wrap_hi_b", 5'h04, 32'd1);
    wr(5'h04, 32'd0);
    wr(5'h00, 32'hFFFF_FFFE);
    rd_chk("wrap_lo_c", 5'h00, 32'hFFFF_FFFE);
    rd_chk("wrap_hi_c", 5'h04, 32'd0);
    rd_chk("wrap_lo_d", 5'h00, 32'd0);
    rd_chk("wrap_hi_d", 5'h04, 32'd1);

    // Interrupt timing.
    wr(5'h10, 32'd0);
    wr(5'h04, 32'd0);
    wr(5'h00, 32'd0);
    wr(5'h08, 32'd10);
    wr(5'h0C, 32'd0);
    wr(5'h10, 32'd1);
    repeat (10) @(negedge clk);
    check("irq_before", irq_timer, 0);
    @(negedge clk);
    check("irq_rise", irq_timer, 1);
    wr(5'h0C, 32'd1);
    check("irq_hold", irq_timer, 1);
    @(negedge clk);
    check("irq_fall", irq_timer, 0);

    // Byte enables.
    wr(5'h08, 32'hFFFF_FFFF);
    xfer(1'b1, 5'h08, 32'hAABB_CCDD, 4'b0101, r);
    rd_chk("byte_sel", 5'h08, 32'hFFBB_FFDD);

    // Write/tick collisions.
    wr(5'h00, 32'h100);
    rd_chk("collide_lo", 5'h00, 32'h100);
    wr(5'h04, 32'd5);
    wr(5'h00, 32'hFFFF_FFFE);
    @(negedge clk);
    wr(5'h00, 32'h200);
    rd_chk("collide_carry_lo", 5'h00, 32'h200);
    rd_chk("collide_carry_hi", 5'h04, 32'd6);

    // Back-to-back reads, including the reserved offsets.
    for (int i = 0; i < 6; i++) begin
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.sel = 4'hF;
      bus.adr = {27'd0, b2b_adr[i]};
      @(negedge clk);
      check("b2b_ack", bus.ack, 1);
      check("b2b_dat", bus.dat_s, b2b_exp[i]);
    end
    bus.cyc = 1'b0; bus.stb = 1'b0;
    @(negedge clk);
    check("b2b_ack_end", bus.ack, 0);

    // Asynchronous reset with an ack pending.
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 32'h10;
    @(posedge clk);
    #2;
    check("pend_ack", bus.ack, 1);
    check("pend_irq", irq_timer, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", bus.ack, 0);
    check("mid_rst_dat", bus.dat_s, 0);
    check("mid_rst_irq", irq_timer, 0);
    bus.cyc = 1'b0; bus.stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("post_rst_ctrl", 5'h10, 32'd1);
    rd_chk("post_rst_prescale", 5'h14, 32'd49);
    rd_chk("post_rst_cmp_hi", 5'h0C, 32'hFFFF_FFFF);
    rd_chk("post_rst_mtime", 5'h00, 32'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_timer.md
# wb_timer

Wishbone slave implementing the RISC-V machine timer (64-bit `mtime`/`mtimecmp`) for the Ibex SoC. Sits downstream of the Wishbone interconnect as an additional slave window and drives the core's `irq_timer` input. A programmable prescaler divides the system clock into the `mtime` tick. Registers are 32-bit on the bus, with a latched high word for tear-free 64-bit reads.

## Interface
- `PRESCALE_RST`, default 49: reset value of PRESCALE; one `mtime` tick every PRESCALE+1 clocks.
- `PW`, default 16: prescaler width in bits, range 1..32.
- `clk  in  1`: system clock, same clock as `wb`.
- `rst_n  in  1`: reset, asynchronous, active-low. All state is reset on assertion.
- `wb  wb_if slave modport  -`: Wishbone B4 pipelined slave. Uses `cyc`, `stb`, `we`, `adr`, `sel`, `dat_m` (write data), `dat_s` (read data), `ack`, `stall`, `err`.
- `irq_timer  out  1`: level interrupt to the core, high while `mtime >= mtimecmp`.

## Operation
- Register map decodes `wb.adr[4:2]` only; higher address bits are ignored because the interconnect owns the window.
  - 0x00 MTIME_LO (RW)
  - 0x04 MTIME_HI (RW writes; reads return the latched shadow)
  - 0x08 MTIMECMP_LO (RW)
  - 0x0C MTIMECMP_HI (RW)
  - 0x10 CTRL (RW): bit0 EN; other bits read 0.
  - 0x14 PRESCALE (RW): bits PW-1:0; other bits read 0.
  - 0x18, 0x1C: reads return 0, writes are ignored, `ack` is still given.
- Reset values:
  - `mtime` = 0, `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, shadow = 0.
  - EN = 1, PRESCALE = PRESCALE_RST, prescaler count = 0.
  - `irq_timer` = 0, `wb.ack` = 0, `wb.dat_s` = 0.
- Prescaler:
  - When EN=1, the count increments every clock.
  - When count == PRESCALE, it wraps to 0 and a tick fires.
  - When EN=0, the count holds and no ticks occur.
  - Writing PRESCALE clears the count.
  - PRESCALE=0 means a tick every clock.
- `mtime`:
  - Each tick increments it by 1, with carry from the low to the high word.
  - It wraps from 2^64-1 to 0.
- Byte writes: `wb.sel[i]` gates byte i of every RW register.
- Bus write vs. tick in the same cycle:
  - A bus write to either `mtime` word replaces that word with the written value; the tick is dropped for that word.
  - The other word still takes the carry.
    - Example: writing LO in the same cycle as a carry-out from the old LO still increments HI.
- 64-bit read protocol:
  - A read of MTIME_LO returns the current low word and, in the same cycle, copies the current high word into the shadow.
  - A read of MTIME_HI returns the shadow.
  - Software reads LO then HI.
- Interrupt: `irq_timer` is a register, set to the unsigned compare `mtime >= mtimecmp` from the previous cycle.
- `wb.err` is tied to 0. `wb.stall` is tied to 0: every transfer is accepted.

## Timing
- A transfer is accepted when `wb.cyc & wb.stb` is high (`stall` is always 0).
- `wb.ack` is asserted exactly one cycle after acceptance, for one cycle per accepted transfer.
- Back-to-back strobes give back-to-back acks.
- Read data is valid on `wb.dat_s` in the `ack` cycle. `dat_s` is 0 when `ack` is low.
- Register update timing:
  - Writes take effect at the clock edge of acceptance.
  - A read accepted in the cycle after a write returns the new value.
- Reads sample register state at the acceptance edge.
  - A tick at that same edge is not visible in the returned data.
- If `cyc` drops with an ack pending, the ack is still issued one cycle later.
  - The interconnect ignores it; no state is rolled back.
- `irq_timer` latency: 1 cycle after `mtime >= mtimecmp` becomes true, whether by tick or by a write to either register. Deassertion has the same 1-cycle latency.
- Asynchronous reset mid-transfer:
  - All outputs return to their reset values immediately.
  - The pending ack is discarded.
  - The first transfer after release is accepted normally.

## Test plan
- Reset, then PRESCALE=3 and EN=1:
  - `mtime` increments every 4 clocks.
  - MTIME_LO reads 0,1,2 at successive 4-cycle samples.
  - CTRL reads 1 and PRESCALE reads 3 after reset-release programming.
- Carry and shadow:
  - Write MTIME_HI=0, MTIME_LO=FFFF_FFFE, PRESCALE=0.
  - Read LO then HI across the wrap:
    - A pair with LO=FFFF_FFFF must return HI=0.
    - A pair with LO=0 or 1 must return HI=1.
    - No pair may mix a pre-wrap LO with a post-wrap HI, or the reverse.
- Interrupt timing:
  - Set `mtimecmp`=10 and `mtime`=0 with PRESCALE=0.
  - `irq_timer` rises exactly 1 cycle after `mtime` reaches 10.
  - Writing MTIMECMP_HI=1 drops `irq_timer` 1 cycle after the write's acceptance edge.
- Byte enables: write 0xAABBCCDD to MTIMECMP_LO with `sel`=4'b0101; readback returns 0xFFBBFFDD.
- Write/tick collision:
  - With PRESCALE=0, write MTIME_LO=0x100 in a tick cycle.
  - The next read returns 0x100, not 0x101.
  - A write of MTIME_LO landing on an old-LO carry-out still increments HI.
- Bus protocol:
  - 6 back-to-back accepted reads give 6 consecutive acks, each 1 cycle after its strobe.
  - A read of offset 0x1C returns 0 with `ack`.
  - Asserting `rst_n`=0 during a pending ack clears `ack` immediately.
